// File: rtl/apb_cmd_master_if.sv
// Bundle of the command stream, response stream and APB bus around apb_cmd_master.
// The master modport is the view of the master block itself; slave is the surrounding environment.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_tmo;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
           paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
           paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 master: one command in, one SETUP/ACCESS transfer, one response out.
// ACCESS phases that wait too long for pready are aborted with rsp_err/rsp_tmo.
module apb_cmd_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  apb_cmd_master_if.master  bus
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_tmo_q, rsp_tmo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Outputs come from next-state values so each flop already shows the state being entered.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_wdata;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready is checked before the timeout so a same-edge arrival completes normally.
        if (bus.pready) begin
          rsp_err_d   = bus.pslverr;
          rsp_tmo_d   = 1'b0;
          rsp_rdata_d = (pwrite_q || bus.pslverr) ? '0 : bus.prdata;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (TIMEOUT != 0 && cnt_q == TMO_LAST) begin
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b1;
          rsp_rdata_d = '0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
      cnt_q       <= cnt_d;
    end
  end

  // Ready tracks IDLE directly so a command can be taken on the very first edge after reset release.
  assign bus.cmd_ready = rstn && (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_tmo   = rsp_tmo_q;
  assign bus.paddr     = paddr_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed scenarios plus randomized transfers
// checked against a transfer-level model of wait states, slave errors and timeout.
module tb_apb_cmd_master;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  apb_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Transfer-level model: number of ACCESS cycles a slave with 'waits' wait states produces.
  function automatic int exp_access(input int waits);
    return (waits >= TMO) ? TMO : waits + 1;
  endfunction

  // Drives one command at a negedge, plays the slave, and checks the whole transfer.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int waits, input logic slverr, input logic [DW-1:0] rdata,
                         input int hold, input bit keep_valid, input bit late_pready);
    int acc;
    logic exp_tmo, exp_err;
    logic [DW-1:0] exp_rdata;
    exp_tmo   = (waits >= TMO);
    exp_err   = exp_tmo || slverr;
    exp_rdata = (exp_tmo || wr || slverr) ? '0 : rdata;

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL cmd_ready_idle got %b exp 1", bus.cmd_ready);
    end
    @(negedge clk);
    if (!keep_valid) bus.cmd_valid = 1'b0;
    checks++;
    if ({bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid} !== 4'b1000) begin
      errors++; $display("[TB] FAIL setup_ctrl got psel/pen/rdy/rv=%b exp 1000",
                         {bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid});
    end
    checks++;
    if (bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== wdata) begin
      errors++; $display("[TB] FAIL setup_bus got %h/%b/%h exp %h/%b/%h",
                         bus.paddr, bus.pwrite, bus.pwdata, addr, wr, wdata);
    end

    acc = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!(bus.psel && bus.penable)) break;
      acc++;
      bus.pready  = (acc > waits);
      bus.pslverr = bus.pready && slverr;
      bus.prdata  = bus.pready ? rdata : $urandom;
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    checks++;
    if (acc !== exp_access(waits)) begin
      errors++; $display("[TB] FAIL access_cycles got %0d exp %0d", acc, exp_access(waits));
    end
    checks++;
    if ({bus.rsp_valid, bus.psel, bus.penable} !== 3'b100) begin
      errors++; $display("[TB] FAIL resp_ctrl got rv/psel/pen=%b exp 100",
                         {bus.rsp_valid, bus.psel, bus.penable});
    end
    checks++;
    if ({bus.rsp_err, bus.rsp_tmo} !== {exp_err, exp_tmo} || bus.rsp_rdata !== exp_rdata) begin
      errors++; $display("[TB] FAIL resp_payload got err=%b tmo=%b rdata=%h exp err=%b tmo=%b rdata=%h",
                         bus.rsp_err, bus.rsp_tmo, bus.rsp_rdata, exp_err, exp_tmo, exp_rdata);
    end

    for (int h = 0; h < hold; h++) begin
      bus.pready = late_pready;
      bus.prdata = $urandom;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.psel !== 1'b0 ||
          {bus.rsp_err, bus.rsp_tmo} !== {exp_err, exp_tmo} || bus.rsp_rdata !== exp_rdata) begin
        errors++; $display("[TB] FAIL resp_hold got rv=%b rdy=%b psel=%b err=%b tmo=%b rdata=%h exp 1/0/0/%b/%b/%h",
                           bus.rsp_valid, bus.cmd_ready, bus.psel, bus.rsp_err, bus.rsp_tmo,
                           bus.rsp_rdata, exp_err, exp_tmo, exp_rdata);
      end
    end
    bus.pready = 1'b0;

    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.cmd_ready, bus.psel} !== 3'b010) begin
      errors++; $display("[TB] FAIL resp_exit got rv/rdy/psel=%b exp 010",
                         {bus.rsp_valid, bus.cmd_ready, bus.psel});
    end
    checks++;
    if (bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== wdata) begin
      errors++; $display("[TB] FAIL bus_hold got %h/%b/%h exp %h/%b/%h",
                         bus.paddr, bus.pwrite, bus.pwdata, addr, wr, wdata);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.psel, bus.penable, bus.pwrite, bus.rsp_err, bus.rsp_tmo} !== 7'b0 ||
        bus.paddr !== '0 || bus.pwdata !== '0 || bus.rsp_rdata !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs got rdy=%b rv=%b psel=%b pen=%b paddr=%h pwdata=%h exp all 0",
                         bus.cmd_ready, bus.rsp_valid, bus.psel, bus.penable, bus.paddr, bus.pwdata);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.psel !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_release got rdy=%b psel=%b exp 1/0", bus.cmd_ready, bus.psel);
    end
  endtask

  task automatic test_write_zero_wait();
    run_txn(1'b1, 12'h000, 32'h00AB_00CD, 0, 1'b0, 32'h1111_2222, 0, 1'b0, 1'b0);
  endtask

  task automatic test_read_wait();
    run_txn(1'b0, 12'h018, 32'hCAFE_0000, 1, 1'b0, 32'h5500_1234, 1, 1'b0, 1'b0);
  endtask

  task automatic test_slverr();
    run_txn(1'b0, 12'h004, 32'h0, 0, 1'b1, 32'h0000_DEAD, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 12'h010, 32'h0, 100, 1'b0, 32'h7777_7777, 3, 1'b0, 1'b1);
    run_txn(1'b0, 12'h014, 32'h0, TMO - 1, 1'b0, 32'h1234_5678, 0, 1'b0, 1'b0);
    run_txn(1'b1, 12'h01C, 32'hA5A5_5A5A, TMO, 1'b0, 32'h0, 1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 12'h030, 32'h1357_9BDF, 0, 1'b0, 32'h0, 5, 1'b1, 1'b0);
    run_txn(1'b0, 12'h034, 32'h0, 2, 1'b0, 32'hFEED_BEEF, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_access();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 12'h020;
    bus.cmd_wdata = 32'h0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.psel, bus.penable} !== 2'b11) begin
      errors++; $display("[TB] FAIL pre_reset_access got psel/pen=%b exp 11", {bus.psel, bus.penable});
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0000) begin
      errors++; $display("[TB] FAIL async_reset got psel/pen/rv/rdy=%b exp 0000",
                         {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready});
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.psel} !== 3'b100) begin
      errors++; $display("[TB] FAIL after_reset got rdy/rv/psel=%b exp 100",
                         {bus.cmd_ready, bus.rsp_valid, bus.psel});
    end
    run_txn(1'b0, 12'h024, 32'h0, 0, 1'b0, 32'h0BAD_F00D, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int r, waits;
    for (int i = 0; i < 24; i++) begin
      r = int'($urandom_range(0, 7));
      if (r == 0)      waits = TMO + int'($urandom_range(0, 3));
      else if (r == 1) waits = TMO - 1;
      else             waits = int'($urandom_range(0, 3));
      run_txn(1'($urandom), AW'($urandom), $urandom, waits, ($urandom_range(0, 3) == 0),
              $urandom, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
